// File: rtl/writeback_buffer.sv
// writeback_buffer
// FIFO of dirty lines evicted by the cache on their way to main memory.
// A second write to a line that is already queued replaces that line's data in place.
// The line currently being written to memory is the exception: it is never modified.
// A combinational snoop port lets a read miss pick up a line that is still queued.
// Lines drain to memory one at a time through a two-state request/acknowledge FSM.

module writeback_buffer #(
    parameter int DEPTH       = 4,
    parameter int LINE_BITS   = 512,
    parameter int ADDR_BITS   = 32,
    parameter int OFFSET_BITS = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    output logic                   wb_ready,
    input  logic [ADDR_BITS-1:0]   wb_addr,
    input  logic [LINE_BITS-1:0]   wb_data,
    input  logic [ADDR_BITS-1:0]   snoop_addr,
    output logic                   snoop_hit,
    output logic [LINE_BITS-1:0]   snoop_data,
    output logic                   mem_req,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [LINE_BITS-1:0]   mem_data,
    input  logic                   mem_ack,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = ADDR_BITS - OFFSET_BITS;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // Entry storage: valid flag, line address, line data
    logic [DEPTH-1:0]     r_valid;
    logic [LW-1:0]        r_line [DEPTH];
    logic [LINE_BITS-1:0] r_data [DEPTH];
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;

    // Drain side
    logic [0:0]           r_state;
    logic                 r_mem_req;
    logic [ADDR_BITS-1:0] r_mem_addr;
    logic [LINE_BITS-1:0] r_mem_data;

    logic [LW-1:0]        w_wb_line;
    logic [LW-1:0]        w_snoop_line;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_in_flight;
    logic [DEPTH-1:0]     w_merge_vec;
    logic                 w_merge_hit;
    logic [PW-1:0]        w_merge_idx;
    logic                 w_push_new;
    logic                 w_fwd_head;
    logic [DEPTH-1:0]     w_snp_nh_vec;
    logic                 w_snp_nh_hit;
    logic [LINE_BITS-1:0] w_snp_nh_data;
    logic                 w_snp_hd_hit;
    logic                 w_unused_offset;

    // Offset bits play no part in any compare.
    assign w_unused_offset = ^{wb_addr[OFFSET_BITS-1:0], snoop_addr[OFFSET_BITS-1:0]};

    assign w_wb_line    = wb_addr[ADDR_BITS-1:OFFSET_BITS];
    assign w_snoop_line = snoop_addr[ADDR_BITS-1:OFFSET_BITS];
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == {CW{1'b0}});
    assign w_in_flight  = (r_state == ST_REQ);
    // A push is blocked whenever the buffer is full, even if a pop happens on the same edge.
    assign w_push       = wb_valid && !w_full;
    assign w_pop        = w_in_flight && mem_ack;
    assign w_push_new   = w_push && !w_merge_hit;
    // Coalescing into an idle head on the edge the FSM latches it: the new data goes straight to memory.
    assign w_fwd_head   = w_push && w_merge_hit && (w_merge_idx == r_head) && !w_in_flight;

    // Coalesce candidates: valid entries on the pushed line, excluding the in-flight head.
    always_comb begin
        w_merge_vec = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_merge_vec[i] = r_valid[i] && (r_line[i] == w_wb_line) &&
                             !(w_in_flight && (PW'(i) == r_head));
        end
    end

    // Encode the (at most one) coalesce candidate.
    always_comb begin
        w_merge_hit = 1'b0;
        w_merge_idx = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_merge_hit = w_merge_hit | w_merge_vec[i];
            w_merge_idx = w_merge_idx | (PW'(i) & {PW{w_merge_vec[i]}});
        end
    end

    // Snoop matches on non-head entries (the newer copy of a line, if there is one).
    always_comb begin
        w_snp_nh_vec  = {DEPTH{1'b0}};
        w_snp_nh_hit  = 1'b0;
        w_snp_nh_data = {LINE_BITS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_snp_nh_vec[i] = r_valid[i] && (r_line[i] == w_snoop_line) && (PW'(i) != r_head);
            w_snp_nh_hit    = w_snp_nh_hit | w_snp_nh_vec[i];
            w_snp_nh_data   = w_snp_nh_data | (r_data[i] & {LINE_BITS{w_snp_nh_vec[i]}});
        end
    end

    assign w_snp_hd_hit = r_valid[r_head] && (r_line[r_head] == w_snoop_line);

    // Snoop result: the newer non-head copy wins over the head entry.
    always_comb begin
        snoop_hit  = w_snp_nh_hit | w_snp_hd_hit;
        snoop_data = {LINE_BITS{1'b0}};
        if (w_snp_nh_hit) begin
            snoop_data = w_snp_nh_data;
        end else if (w_snp_hd_hit) begin
            snoop_data = r_data[r_head];
        end else begin
            snoop_data = {LINE_BITS{1'b0}};
        end
    end

    // FIFO storage: pop at head, then either coalesce in place or append at tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= {DEPTH{1'b0}};
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_line[i] <= {LW{1'b0}};
                r_data[i] <= {LINE_BITS{1'b0}};
            end
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_push && w_merge_hit) begin
                r_data[w_merge_idx] <= wb_data;
            end else if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_line[r_tail]  <= w_wb_line;
                r_data[r_tail]  <= wb_data;
                r_tail          <= r_tail + PW'(1);
            end
            r_count <= r_count + {{PW{1'b0}}, w_push_new} - {{PW{1'b0}}, w_pop};
        end
    end

    // Drain FSM: latch the head line into the memory port, hold the request until it is acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= {ADDR_BITS{1'b0}};
            r_mem_data <= {LINE_BITS{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state    <= ST_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {r_line[r_head], {OFFSET_BITS{1'b0}}};
                        r_mem_data <= w_fwd_head ? wb_data : r_data[r_head];
                    end else begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                    end else begin
                        r_state   <= ST_REQ;
                        r_mem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign wb_ready = !w_full;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer.
// The reference model is a queue of {line address, data} plus an "in flight" flag.
// The bench first runs directed steps, then a randomized phase.
// Every cycle it compares all outputs against the model.

module tb_writeback_buffer;

    localparam int DEPTH       = 4;
    localparam int LINE_BITS   = 512;
    localparam int ADDR_BITS   = 32;
    localparam int OFFSET_BITS = 6;
    localparam int CW          = $clog2(DEPTH) + 1;
    localparam logic [ADDR_BITS-1:0] LMASK = {{(ADDR_BITS-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [ADDR_BITS-1:0] wb_addr;
    logic [LINE_BITS-1:0] wb_data;
    logic [ADDR_BITS-1:0] snoop_addr;
    logic                 snoop_hit;
    logic [LINE_BITS-1:0] snoop_data;
    logic                 mem_req;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [LINE_BITS-1:0] mem_data;
    logic                 mem_ack;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;

    writeback_buffer #(
        .DEPTH(DEPTH), .LINE_BITS(LINE_BITS), .ADDR_BITS(ADDR_BITS), .OFFSET_BITS(OFFSET_BITS)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .snoop_addr(snoop_addr), .snoop_hit(snoop_hit), .snoop_data(snoop_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [ADDR_BITS-1:0] qa[$];
    logic [LINE_BITS-1:0] qd[$];
    bit                   busy;
    logic [ADDR_BITS-1:0] cur_addr;
    logic [LINE_BITS-1:0] cur_data;

    int errors = 0;
    int checks = 0;

    function automatic logic [ADDR_BITS-1:0] la(input logic [ADDR_BITS-1:0] a);
        return a & LMASK;
    endfunction

    function automatic logic [LINE_BITS-1:0] rnd_line();
        logic [LINE_BITS-1:0] d;
        for (int j = 0; j < LINE_BITS / 32; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [LINE_BITS-1:0] obs, input logic [LINE_BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qd.delete();
        busy = 1'b0;
    endtask

    // Advance the model across one rising edge, using the inputs currently applied.
    task automatic model_edge();
        int  k;
        bit  push_ok;
        bit  pop;
        bit  start;
        push_ok = wb_valid && (qa.size() < DEPTH);
        pop     = busy && mem_ack;
        start   = !busy && (qa.size() != 0);
        k = -1;
        if (push_ok) begin
            for (int i = 0; i < qa.size(); i++) begin
                if (qa[i] == la(wb_addr) && !(busy && i == 0)) k = i;
            end
        end
        if (push_ok && k >= 0) qd[k] = wb_data;
        if (start) begin
            busy     = 1'b1;
            cur_addr = qa[0];
            cur_data = qd[0];
        end
        if (pop) begin
            void'(qa.pop_front());
            void'(qd.pop_front());
            busy = 1'b0;
        end
        if (push_ok && k < 0) begin
            qa.push_back(la(wb_addr));
            qd.push_back(wb_data);
        end
    endtask

    task automatic check_all();
        bit                   eh;
        logic [LINE_BITS-1:0] ed;
        chk("count", LINE_BITS'(count), LINE_BITS'(qa.size()));
        chk("full", LINE_BITS'(full), LINE_BITS'(qa.size() == DEPTH));
        chk("empty", LINE_BITS'(empty), LINE_BITS'(qa.size() == 0));
        chk("wb_ready", LINE_BITS'(wb_ready), LINE_BITS'(qa.size() != DEPTH));
        chk("mem_req", LINE_BITS'(mem_req), LINE_BITS'(busy));
        if (busy) begin
            chk("mem_addr", LINE_BITS'(mem_addr), LINE_BITS'(cur_addr));
            chk("mem_data", mem_data, cur_data);
        end
        // Newest matching copy wins.
        eh = 1'b0;
        ed = '0;
        for (int i = qa.size() - 1; i >= 0; i--) begin
            if (!eh && qa[i] == la(snoop_addr)) begin
                eh = 1'b1;
                ed = qd[i];
            end
        end
        chk("snoop_hit", LINE_BITS'(snoop_hit), LINE_BITS'(eh));
        chk("snoop_data", snoop_data, ed);
    endtask

    // Apply inputs, clock once, then check outputs on the falling edge.
    task automatic drive(input bit v, input logic [ADDR_BITS-1:0] a, input logic [LINE_BITS-1:0] d, input bit ack);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
        mem_ack  = ack;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    logic [LINE_BITS-1:0] dA, dB, dC;

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; mem_ack = 1'b0; snoop_addr = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_count", LINE_BITS'(count), '0);
        chk("reset_empty", LINE_BITS'(empty), LINE_BITS'(1'b1));
        chk("reset_mem_addr", LINE_BITS'(mem_addr), '0);
        chk("reset_mem_data", mem_data, '0);
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);

        // Single drain of one line
        drive(1'b1, 32'h0000_0140, LINE_BITS'(32'hAAAA_AAAA), 1'b0);
        chk("t2_no_req_yet", LINE_BITS'(mem_req), LINE_BITS'(1'b0));
        drive(1'b0, '0, '0, 1'b0);
        chk("t2_mem_req", LINE_BITS'(mem_req), LINE_BITS'(1'b1));
        chk("t2_mem_addr", LINE_BITS'(mem_addr), LINE_BITS'(32'h0000_0140));
        drive(1'b0, '0, '0, 1'b1);
        chk("t2_req_drop", LINE_BITS'(mem_req), LINE_BITS'(1'b0));
        chk("t2_count", LINE_BITS'(count), '0);

        // Coalescing, and no coalescing into the in-flight head
        dA = rnd_line(); dB = rnd_line(); dC = rnd_line();
        drive(1'b1, 32'h0000_1000, rnd_line(), 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b1, 32'h0000_2040, dA, 1'b0);
        drive(1'b1, 32'h0000_2044, dB, 1'b0);
        chk("t3_count2", LINE_BITS'(count), LINE_BITS'(2));
        snoop_addr = 32'h0000_207C;
        #1;
        chk("t3_snoop_hit", LINE_BITS'(snoop_hit), LINE_BITS'(1'b1));
        chk("t3_snoop_data", snoop_data, dB);
        drive(1'b1, 32'h0000_1000, dC, 1'b0);
        chk("t3_count3", LINE_BITS'(count), LINE_BITS'(3));
        snoop_addr = 32'h0000_1000;
        #1;
        chk("t3_snoop_newer", snoop_data, dC);

        // Snoop miss with the buffer non-empty
        snoop_addr = 32'h0000_3000;
        #1;
        chk("t6_miss_hit", LINE_BITS'(snoop_hit), LINE_BITS'(1'b0));
        chk("t6_miss_data", snoop_data, '0);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, '0, 1'b1);
        chk("t3_drained", LINE_BITS'(empty), LINE_BITS'(1'b1));

        // Fill to full; a further push is refused
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h0000_4000 + 32'(i * 64), rnd_line(), 1'b0);
        chk("t4_full", LINE_BITS'(full), LINE_BITS'(1'b1));
        chk("t4_not_ready", LINE_BITS'(wb_ready), LINE_BITS'(1'b0));
        drive(1'b1, 32'h0000_5000, rnd_line(), 1'b0);
        chk("t4_refused", LINE_BITS'(count), LINE_BITS'(4));
        drive(1'b0, '0, '0, 1'b1);
        chk("t4_count3", LINE_BITS'(count), LINE_BITS'(3));
        chk("t4_ready", LINE_BITS'(wb_ready), LINE_BITS'(1'b1));
        for (int i = 0; i < 8; i++) drive(1'b0, '0, '0, 1'b1);

        // Push and pop on the same edge
        drive(1'b1, 32'h0000_6000, rnd_line(), 1'b0);
        drive(1'b1, 32'h0000_6040, rnd_line(), 1'b0);
        drive(1'b1, 32'h0000_6080, rnd_line(), 1'b1);
        chk("t5_count", LINE_BITS'(count), LINE_BITS'(2));
        for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, 1'b1);

        // Asynchronous reset in the middle of a drain
        drive(1'b1, 32'h0000_7000, rnd_line(), 1'b0);
        drive(1'b1, 32'h0000_7040, rnd_line(), 1'b0);
        chk("t1_pre_req", LINE_BITS'(mem_req), LINE_BITS'(1'b1));
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t1_ready", LINE_BITS'(wb_ready), LINE_BITS'(1'b1));
        chk("t1_empty", LINE_BITS'(empty), LINE_BITS'(1'b1));
        chk("t1_count", LINE_BITS'(count), '0);
        chk("t1_mem_req", LINE_BITS'(mem_req), LINE_BITS'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);

        // Randomized traffic over a small set of lines so coalescing happens
        for (int n = 0; n < 400; n++) begin
            snoop_addr = 32'h0000_8000 + 32'($urandom_range(0, 7) * 64) + 32'($urandom_range(0, 63));
            drive(($urandom_range(0, 9) < 6),
                  32'h0000_8000 + 32'($urandom_range(0, 7) * 64) + 32'($urandom_range(0, 63)),
                  rnd_line(), $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 10; i++) drive(1'b0, '0, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
